// File: rtl/arbiter_nx1.sv
// ---------------------------------------------------------------------------
// arbiter_nx1
//
// Round-robin arbiter connecting N upstream bus masters to a single slave
// (the memory controller). One access is in flight at a time. An AMO read
// locks the slave to its master so that the write half follows without
// interleaving. A timeout releases the lock if the write half never shows up.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_bus_en[N]         per-master request, held until acked
//   i_wr_en[N]          per-master write (1) / read (0)
//   i_wr_data[32N]      write data, master k at [32k+31:32k]
//   i_addr[32N]         address, same packing
//   i_byte_en[4N]       byte enables, master k at [4k+3:4k]
//   i_atomic[N]         access belongs to an A-extension instruction
//   i_operation[7N]     funct7 of the atomic instruction, master k at [7k+6:7k]
//   o_ack[N]            one-hot ack towards the granted master
//   o_rd_data[32N]      slave read data broadcast to every master slot
//   i_ack, i_rd_data    slave ack and read data
//   o_id                index of the granted master
//   o_bus_en ... o_operation   slave-side request, muxed from the granted master
// ---------------------------------------------------------------------------
module arbiter_nx1 #(
    parameter int N_MASTERS    = 2,
    parameter int LOCK_TIMEOUT = 16,
    parameter int ID_W         = $clog2(N_MASTERS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_MASTERS-1:0]    i_bus_en,
    input  logic [N_MASTERS-1:0]    i_wr_en,
    input  logic [32*N_MASTERS-1:0] i_wr_data,
    input  logic [32*N_MASTERS-1:0] i_addr,
    input  logic [4*N_MASTERS-1:0]  i_byte_en,
    input  logic [N_MASTERS-1:0]    i_atomic,
    input  logic [7*N_MASTERS-1:0]  i_operation,
    output logic [N_MASTERS-1:0]    o_ack,
    output logic [32*N_MASTERS-1:0] o_rd_data,
    input  logic                    i_ack,
    input  logic [31:0]             i_rd_data,
    output logic [ID_W-1:0]         o_id,
    output logic                    o_bus_en,
    output logic                    o_wr_en,
    output logic                    o_atomic,
    output logic [31:0]             o_wr_data,
    output logic [31:0]             o_addr,
    output logic [3:0]              o_byte_en,
    output logic [6:0]              o_operation
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [ID_W-1:0]   grant, grant_next;
    logic [ID_W-1:0]   last, last_next;
    logic [CNT_W-1:0]  lock_cnt, lock_cnt_next;
    logic              follow_up, follow_up_next;

    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   cand;
    logic              found;

    logic [31:0]       wr_data_arr [N_MASTERS];
    logic [31:0]       addr_arr    [N_MASTERS];
    logic [3:0]        byte_en_arr [N_MASTERS];
    logic [6:0]        op_arr      [N_MASTERS];

    logic              sel_bus_en;
    logic              sel_wr_en;
    logic              sel_atomic;
    logic [6:0]        sel_op;
    logic              amo_read;

    // Split the packed per-master buses into arrays so the granted master
    // can be selected with a plain index.
    for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
        assign wr_data_arr[g] = i_wr_data[32*g +: 32];
        assign addr_arr[g]    = i_addr[32*g +: 32];
        assign byte_en_arr[g] = i_byte_en[4*g +: 4];
        assign op_arr[g]      = i_operation[7*g +: 7];
    end

    assign sel_bus_en = i_bus_en[grant];
    assign sel_wr_en  = i_wr_en[grant];
    assign sel_atomic = i_atomic[grant];
    assign sel_op     = op_arr[grant];

    // Every AMO except LR (00010) and SC (00011) is a read followed by a
    // write from the same hart, so only those reads take the lock.
    assign amo_read = sel_atomic && !sel_wr_en &&
                      (sel_op[6:2] != 5'b00010) && (sel_op[6:2] != 5'b00011);

    // Round-robin search starting just after the last granted master, so the
    // master served most recently has the lowest priority.
    always_comb begin
        winner = last;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            cand = ID_W'((int'(last) + i) % N_MASTERS);
            if (!found && i_bus_en[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Next-state logic. The follow-up access granted from LOCK is marked so
    // that its ack always returns to IDLE and a lock can never nest.
    always_comb begin
        state_next     = state;
        grant_next     = grant;
        last_next      = last;
        lock_cnt_next  = lock_cnt;
        follow_up_next = follow_up;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_next     = winner;
                    last_next      = winner;
                    follow_up_next = 1'b0;
                    state_next     = BUSY;
                end
            end
            BUSY: begin
                if (i_ack) begin
                    if (amo_read && !follow_up) begin
                        state_next    = LOCK;
                        lock_cnt_next = CNT_W'(LOCK_TIMEOUT);
                    end else begin
                        state_next = IDLE;
                    end
                end else if (!sel_bus_en) begin
                    state_next = IDLE;
                end
            end
            LOCK: begin
                if (sel_bus_en) begin
                    state_next     = BUSY;
                    follow_up_next = 1'b1;
                end else if (lock_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    lock_cnt_next = lock_cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register. last resets to the top index so master 0 wins the
    // first arbitration.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            grant     <= '0;
            last      <= ID_W'(N_MASTERS - 1);
            lock_cnt  <= '0;
            follow_up <= 1'b0;
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            last      <= last_next;
            lock_cnt  <= lock_cnt_next;
            follow_up <= follow_up_next;
        end
    end

    // Slave-side mux and ack routing, only live while an access is in flight.
    always_comb begin
        o_ack       = '0;
        o_bus_en    = 1'b0;
        o_wr_en     = 1'b0;
        o_atomic    = 1'b0;
        o_wr_data   = '0;
        o_addr      = '0;
        o_byte_en   = '0;
        o_operation = '0;
        if (state == BUSY) begin
            o_bus_en     = sel_bus_en;
            o_wr_en      = sel_wr_en;
            o_atomic     = sel_atomic;
            o_wr_data    = wr_data_arr[grant];
            o_addr       = addr_arr[grant];
            o_byte_en    = byte_en_arr[grant];
            o_operation  = sel_op;
            o_ack[grant] = i_ack;
        end
    end

    assign o_id      = grant;
    assign o_rd_data = {N_MASTERS{i_rd_data}};

endmodule

// File: tb/tb_arbiter_nx1.sv
// ---------------------------------------------------------------------------
// tb_arbiter_nx1
//
// Self-checking bench for arbiter_nx1 with four masters and a short lock
// timeout. A small master/slave model drives the buses; expected grants are
// queued when requests are raised and popped when the DUT acks.
// ---------------------------------------------------------------------------
module tb_arbiter_nx1;

    localparam int N   = 4;
    localparam int T   = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              i_rst;
    logic [N-1:0]      i_bus_en;
    logic [N-1:0]      i_wr_en;
    logic [32*N-1:0]   i_wr_data;
    logic [32*N-1:0]   i_addr;
    logic [4*N-1:0]    i_byte_en;
    logic [N-1:0]      i_atomic;
    logic [7*N-1:0]    i_operation;
    logic [N-1:0]      o_ack;
    logic [32*N-1:0]   o_rd_data;
    logic              i_ack;
    logic [31:0]       i_rd_data;
    logic [IDW-1:0]    o_id;
    logic              o_bus_en;
    logic              o_wr_en;
    logic              o_atomic;
    logic [31:0]       o_wr_data;
    logic [31:0]       o_addr;
    logic [3:0]        o_byte_en;
    logic [6:0]        o_operation;

    logic [31:0]       m_addr [N];
    logic [31:0]       m_data [N];
    logic [6:0]        m_op   [N];

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    addr;
        logic           wr;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              e;
    int                checks   = 0;
    int                failures = 0;
    int                req_left [N];
    logic [N-1:0]      pending;
    int                busy_cnt;

    logic              obs_acked;
    logic              obs_bus_en;
    logic [IDW-1:0]    obs_id;
    logic [N-1:0]      obs_ack;
    logic [31:0]       obs_addr;
    logic              obs_wr;
    logic [31:0]       obs_rd;
    logic [31:0]       obs_drv;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign i_addr[32*g +: 32]     = m_addr[g];
        assign i_wr_data[32*g +: 32]  = m_data[g];
        assign i_operation[7*g +: 7]  = m_op[g];
        assign i_byte_en[4*g +: 4]    = 4'hF;
    end

    arbiter_nx1 #(
        .N_MASTERS    (N),
        .LOCK_TIMEOUT (T),
        .ID_W         (IDW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_bus_en    (i_bus_en),
        .i_wr_en     (i_wr_en),
        .i_wr_data   (i_wr_data),
        .i_addr      (i_addr),
        .i_byte_en   (i_byte_en),
        .i_atomic    (i_atomic),
        .i_operation (i_operation),
        .o_ack       (o_ack),
        .o_rd_data   (o_rd_data),
        .i_ack       (i_ack),
        .i_rd_data   (i_rd_data),
        .o_id        (o_id),
        .o_bus_en    (o_bus_en),
        .o_wr_en     (o_wr_en),
        .o_atomic    (o_atomic),
        .o_wr_data   (o_wr_data),
        .o_addr      (o_addr),
        .o_byte_en   (o_byte_en),
        .o_operation (o_operation)
    );

    // Hold reset for two cycles with every master idle.
    task automatic do_reset();
        @(negedge clk);
        i_rst     = 1'b1;
        i_bus_en  = '0;
        i_wr_en   = '0;
        i_atomic  = '0;
        i_ack     = 1'b0;
        i_rd_data = '0;
        pending   = '0;
        busy_cnt  = 0;
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            m_addr[k]   = '0;
            m_data[k]   = '0;
            m_op[k]     = '0;
            req_left[k] = 0;
        end
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
    endtask

    // Raise a request on master k for 'count' accesses.
    task automatic set_master(input int k, input logic wr, input logic atomic,
                              input logic [6:0] funct7, input logic [31:0] addr,
                              input int count);
        i_bus_en[k] = 1'b1;
        i_wr_en[k]  = wr;
        i_atomic[k] = atomic;
        m_op[k]     = funct7;
        m_addr[k]   = addr;
        m_data[k]   = addr ^ 32'hDEAD_0000;
        req_left[k] = count;
    endtask

    // One clock of the master/slave model. Masters acked last cycle either
    // drop their request or, for an AMO, turn the read into the write half.
    // The slave acks the 'delay'-th cycle of each access.
    task automatic slave_step(input int delay);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (pending[k]) begin
                req_left[k] = req_left[k] - 1;
                if (req_left[k] <= 0)
                    i_bus_en[k] = 1'b0;
                else if (i_atomic[k] && !i_wr_en[k])
                    i_wr_en[k] = 1'b1;
            end
        end
        pending   = '0;
        i_ack     = 1'b0;
        i_rd_data = $urandom;
        #1;
        obs_bus_en = o_bus_en;
        if (o_bus_en) busy_cnt++;
        else          busy_cnt = 0;
        if (o_bus_en && busy_cnt >= delay) begin
            i_ack    = 1'b1;
            busy_cnt = 0;
        end
        #1;
        obs_acked = i_ack;
        obs_id    = o_id;
        obs_ack   = o_ack;
        obs_addr  = o_addr;
        obs_wr    = o_wr_en;
        obs_rd    = 32'(o_rd_data >> (32 * int'(o_id)));
        obs_drv   = i_rd_data;
        pending   = o_ack;
    endtask

    task automatic test_reset();
        do_reset();
        i_rd_data = 32'hA5A5_0001;
        #1;
        checks++;
        if (o_bus_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_bus_en actual=%b required=0", o_bus_en);
        end
        checks++;
        if (o_ack !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_ack actual=%b required=0000", o_ack);
        end
        checks++;
        if (o_id !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_id actual=%0d required=0", o_id);
        end
        checks++;
        if (o_addr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_addr actual=%h required=0", o_addr);
        end
        checks++;
        if (o_rd_data !== {4{32'hA5A5_0001}}) begin
            failures++;
            $display("[TB] FAIL reset_rd_data actual=%h required=%h", o_rd_data, {4{32'hA5A5_0001}});
        end
    endtask

    task automatic test_single_read();
        int  bus_cycles;
        logic done;
        do_reset();
        set_master(2, 1'b0, 1'b0, 7'h00, 32'h0000_0100, 1);
        exp_q.push_back('{id: 2'd2, addr: 32'h0000_0100, wr: 1'b0});
        bus_cycles = 0;
        done = 1'b0;
        for (int s = 0; s < 20 && !done; s++) begin
            slave_step(3);
            if (s == 0) begin
                checks++;
                if (obs_bus_en !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL single_latency bus_en actual=%b required=1", obs_bus_en);
                end
            end
            if (obs_bus_en) bus_cycles++;
            if (obs_acked) begin
                e = exp_q.pop_front();
                checks++;
                if (obs_id !== e.id) begin
                    failures++;
                    $display("[TB] FAIL single_id actual=%0d required=%0d", obs_id, e.id);
                end
                checks++;
                if (obs_ack !== 4'b0100) begin
                    failures++;
                    $display("[TB] FAIL single_ack actual=%b required=0100", obs_ack);
                end
                checks++;
                if (obs_addr !== e.addr) begin
                    failures++;
                    $display("[TB] FAIL single_addr actual=%h required=%h", obs_addr, e.addr);
                end
                checks++;
                if (obs_rd !== obs_drv) begin
                    failures++;
                    $display("[TB] FAIL single_rd_data actual=%h required=%h", obs_rd, obs_drv);
                end
                checks++;
                if (bus_cycles != 3) begin
                    failures++;
                    $display("[TB] FAIL single_busy_len actual=%0d required=3", bus_cycles);
                end
                done = 1'b1;
            end
        end
        slave_step(3);
        checks++;
        if (obs_ack !== 4'b0000 || obs_bus_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_after_ack ack=%b bus_en=%b required=0000/0", obs_ack, obs_bus_en);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL single_timeout outstanding=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        int nxt;
        do_reset();
        for (int k = 0; k < N; k++)
            set_master(k, 1'b0, 1'b0, 7'h00, 32'h0000_0200 + 32'(k * 4), 1000);
        nxt = N - 1;
        for (int j = 0; j < 6; j++) begin
            nxt = (nxt + 1) % N;
            exp_q.push_back('{id: IDW'(nxt), addr: 32'h0000_0200 + 32'(nxt * 4), wr: 1'b0});
        end
        for (int s = 0; s < 60 && exp_q.size() != 0; s++) begin
            slave_step(2);
            if (obs_acked) begin
                e = exp_q.pop_front();
                checks++;
                if (obs_id !== e.id) begin
                    failures++;
                    $display("[TB] FAIL rr_id actual=%0d required=%0d", obs_id, e.id);
                end
                checks++;
                if (obs_ack !== (4'b0001 << e.id) || obs_addr !== e.addr) begin
                    failures++;
                    $display("[TB] FAIL rr_ack actual=%b/%h required=%b/%h", obs_ack, obs_addr, 4'b0001 << e.id, e.addr);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL rr_timeout outstanding=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_amo_lock();
        int ack_step;
        do_reset();
        set_master(0, 1'b0, 1'b1, 7'b0000000, 32'h0000_0300, 2);
        set_master(1, 1'b0, 1'b0, 7'h00, 32'h0000_0400, 1);
        exp_q.push_back('{id: 2'd0, addr: 32'h0000_0300, wr: 1'b0});
        exp_q.push_back('{id: 2'd0, addr: 32'h0000_0300, wr: 1'b1});
        exp_q.push_back('{id: 2'd1, addr: 32'h0000_0400, wr: 1'b0});
        ack_step = -1;
        for (int s = 0; s < 40 && exp_q.size() != 0; s++) begin
            slave_step(1);
            if (ack_step >= 0 && s == ack_step + 1) begin
                checks++;
                if (obs_bus_en !== 1'b0 || obs_id !== 2'd0) begin
                    failures++;
                    $display("[TB] FAIL amo_lock_idle bus_en=%b id=%0d required=0/0", obs_bus_en, obs_id);
                end
            end
            if (ack_step >= 0 && s == ack_step + 2) begin
                checks++;
                if (obs_bus_en !== 1'b1 || obs_id !== 2'd0) begin
                    failures++;
                    $display("[TB] FAIL amo_followup bus_en=%b id=%0d required=1/0", obs_bus_en, obs_id);
                end
            end
            if (obs_acked) begin
                if (ack_step < 0) ack_step = s;
                e = exp_q.pop_front();
                checks++;
                if (obs_id !== e.id || obs_wr !== e.wr) begin
                    failures++;
                    $display("[TB] FAIL amo_order id=%0d wr=%b required=%0d/%b", obs_id, obs_wr, e.id, e.wr);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL amo_timeout outstanding=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_lock_timeout();
        int ack_step;
        int gap;
        do_reset();
        set_master(0, 1'b0, 1'b1, 7'b0000100, 32'h0000_0500, 1);
        set_master(1, 1'b0, 1'b0, 7'h00, 32'h0000_0600, 1);
        exp_q.push_back('{id: 2'd0, addr: 32'h0000_0500, wr: 1'b0});
        exp_q.push_back('{id: 2'd1, addr: 32'h0000_0600, wr: 1'b0});
        ack_step = -1;
        gap = -1;
        for (int s = 0; s < 40 && exp_q.size() != 0; s++) begin
            slave_step(1);
            if (ack_step >= 0 && gap < 0 && obs_bus_en) gap = s - ack_step;
            if (obs_acked) begin
                if (ack_step < 0) ack_step = s;
                e = exp_q.pop_front();
                checks++;
                if (obs_id !== e.id) begin
                    failures++;
                    $display("[TB] FAIL timeout_order actual=%0d required=%0d", obs_id, e.id);
                end
            end
        end
        checks++;
        if (gap != T + 3) begin
            failures++;
            $display("[TB] FAIL timeout_gap actual=%0d required=%0d", gap, T + 3);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL timeout_outstanding actual=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_lr_no_lock();
        int ack_step;
        int gap;
        do_reset();
        set_master(1, 1'b0, 1'b1, 7'b0001000, 32'h0000_0700, 1);
        set_master(3, 1'b0, 1'b0, 7'h00, 32'h0000_0800, 1);
        exp_q.push_back('{id: 2'd1, addr: 32'h0000_0700, wr: 1'b0});
        exp_q.push_back('{id: 2'd3, addr: 32'h0000_0800, wr: 1'b0});
        ack_step = -1;
        gap = -1;
        for (int s = 0; s < 40 && exp_q.size() != 0; s++) begin
            slave_step(1);
            if (ack_step >= 0 && gap < 0 && obs_bus_en) gap = s - ack_step;
            if (obs_acked) begin
                if (ack_step < 0) ack_step = s;
                e = exp_q.pop_front();
                checks++;
                if (obs_id !== e.id) begin
                    failures++;
                    $display("[TB] FAIL lr_order actual=%0d required=%0d", obs_id, e.id);
                end
            end
        end
        checks++;
        if (gap != 2) begin
            failures++;
            $display("[TB] FAIL lr_gap actual=%0d required=2", gap);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL lr_outstanding actual=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset_during_ack();
        do_reset();
        set_master(2, 1'b0, 1'b0, 7'h00, 32'h0000_0900, 100);
        slave_step(100);
        checks++;
        if (obs_bus_en !== 1'b1 || obs_id !== 2'd2) begin
            failures++;
            $display("[TB] FAIL rstack_grant bus_en=%b id=%0d required=1/2", obs_bus_en, obs_id);
        end
        @(negedge clk);
        i_ack = 1'b1;
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_ack !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL rstack_ack_before actual=%b required=0100", o_ack);
        end
        @(negedge clk);
        i_rst = 1'b0;
        set_master(0, 1'b0, 1'b0, 7'h00, 32'h0000_0A00, 1);
        #1;
        checks++;
        if (o_ack !== 4'b0000 || o_bus_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstack_after ack=%b bus_en=%b required=0000/0", o_ack, o_bus_en);
        end
        @(negedge clk);
        i_ack = 1'b0;
        #1;
        checks++;
        if (o_bus_en !== 1'b1 || o_id !== 2'd0) begin
            failures++;
            $display("[TB] FAIL rstack_first_grant bus_en=%b id=%0d required=1/0", o_bus_en, o_id);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_amo_lock();
        test_lock_timeout();
        test_lr_no_lock();
        test_reset_during_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
